// File: rtl/arc4_pkg.sv
// Shared sizes, FSM state type and seven-segment helper for the ARC4 S-array init slice.
package arc4_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MEM_DEPTH = 256;
    localparam logic [6:0]  HEX_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } init_state_t;

    // Active-low segments, bit 0 = segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        seg = HEX_BLANK;
        case (v)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = HEX_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/task1_init.sv
// S-array initialiser: walks i = 0..255 once after reset, emitting one write per cycle.
module init
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
    output logic              busy,
    output logic              done
);

    init_state_t       state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        wren    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                wren = 1'b1;
                busy = 1'b1;
                i_d  = i_q + 1'b1;
                if (i_q == '1) state_d = DONE;
            end
            DONE: done = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign addr   = i_q;
    assign wrdata = DATA_W'(i_q);

endmodule

// File: rtl/task1.sv
// Top: S-array memory, LED/HEX mapping. Define TASK1_HEX_DEBUG_EN to show i on HEX1:HEX0.
module task1
    import arc4_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
    logic              busy;
    logic              done;
    logic              unused_key;

    logic [DATA_W-1:0] s_mem [MEM_DEPTH];

    assign rst        = KEY[3];
    assign unused_key = ^KEY[2:0];

    init u_init (
        .clk    (CLOCK_50),
        .rst    (rst),
        .addr   (addr),
        .wrdata (wrdata),
        .wren   (wren),
        .busy   (busy),
        .done   (done)
    );

    // Gate with rst so a reset edge landing mid-fill writes nothing.
    always_ff @(posedge CLOCK_50) begin
        if (wren && !rst) s_mem[addr] <= wrdata;
    end

    assign LEDR = {8'b0, busy, done};

`ifdef TASK1_HEX_DEBUG_EN
    assign HEX0 = hex_to_seg(addr[3:0]);
    assign HEX1 = hex_to_seg(addr[7:4]);
`else
    assign HEX0 = HEX_BLANK;
    assign HEX1 = HEX_BLANK;
`endif
    assign HEX2 = HEX_BLANK;
    assign HEX3 = HEX_BLANK;
    assign HEX4 = HEX_BLANK;
    assign HEX5 = HEX_BLANK;

endmodule

// File: tb/tb_task1.sv
// Self-checking bench for task1 against an edge-count model of the fill sequence.
module tb_task1;

    logic       clk;
    logic [3:0] KEY;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int total;
    int bad;
    int k;                     // rising edges seen with reset low since the last reset edge
    logic [7:0] ref_mem [256];

    task1 dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: first edge after release enters FILL; edges 2..257 write address k-2; DONE after edge 257.
    function automatic logic [9:0] exp_led(input int n);
        if (n == 0) return 10'd0;
        if (n <= 256) return 10'd2;
        return 10'd1;
    endfunction

    function automatic logic [7:0] exp_i(input int n);
        if (n >= 1 && n <= 256) return 8'(n - 1);
        return 8'd0;
    endfunction

    function automatic logic [6:0] seg_model(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic logic [13:0] exp_hex10(input int n);
`ifdef TASK1_HEX_DEBUG_EN
        logic [7:0] iv;
        iv = exp_i(n);
        return {seg_model(iv[7:4]), seg_model(iv[3:0])};
`else
        return {7'h7F, 7'h7F};
`endif
    endfunction

    task automatic tick();
        KEY[2:0] = 3'($urandom);
        @(posedge clk);
        if (KEY[3]) k = 0;
        else begin
            k++;
            if (k >= 2 && k <= 257) ref_mem[k-2] = 8'(k - 2);
        end
        @(negedge clk);
    endtask

    task automatic preload_aa();
        for (int a = 0; a < 256; a++) begin
            dut.s_mem[a] = 8'hAA;
            ref_mem[a]   = 8'hAA;
        end
    endtask

    task automatic test_reset();
        int errs;
        KEY = 4'b1000;
        k = 0;
        preload_aa();
        for (int c = 0; c < 4; c++) tick();
        total++;
        if (LEDR !== 10'd0) begin
            bad++; $display("FAIL reset_ledr: got %h want %h", LEDR, 10'd0);
        end
        total++;
        if ({HEX5, HEX4, HEX3, HEX2} !== {4{7'h7F}} || {HEX1, HEX0} !== exp_hex10(0)) begin
            bad++; $display("FAIL reset_hex: got %h %h %h %h %h %h", HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
        end
        errs = 0;
        for (int a = 0; a < 256; a++) if (dut.s_mem[a] !== 8'hAA) errs++;
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL reset_no_write: got %0d changed locations want 0", errs);
        end
    endtask

    task automatic run_fill(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            total++;
            if (LEDR !== exp_led(k)) begin
                bad++; $display("FAIL %s_ledr k=%0d: got %h want %h", tag, k, LEDR, exp_led(k));
            end
            total++;
            if ({HEX1, HEX0} !== exp_hex10(k) || {HEX5, HEX4, HEX3, HEX2} !== {4{7'h7F}}) begin
                bad++; $display("FAIL %s_hex k=%0d: got %h%h want %h", tag, k, HEX1, HEX0, exp_hex10(k));
            end
`ifdef TASK1_HEX_DEBUG_EN
            if (k == 61) begin
                total++;
                if (HEX1 !== 7'h30 || HEX0 !== 7'h46) begin
                    bad++; $display("FAIL %s_hex_3c: got %h %h want 30 46", tag, HEX1, HEX0);
                end
            end
`endif
        end
    endtask

    task automatic scan_mem(input string tag);
        int errs;
        errs = 0;
        for (int a = 0; a < 256; a++) begin
            if (dut.s_mem[a] !== ref_mem[a]) begin
                if (errs < 4) $display("FAIL %s_mem[%0d]: got %h want %h", tag, a, dut.s_mem[a], ref_mem[a]);
                errs++;
            end
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL %s_mem_scan: got %0d wrong locations want 0", tag, errs);
        end
    endtask

    task automatic test_fill();
        KEY[3] = 1'b0;
        run_fill("fill", 257);
        total++;
        if (dut.s_mem[0] !== 8'd0 || dut.s_mem[128] !== 8'd128 || dut.s_mem[255] !== 8'd255) begin
            bad++; $display("FAIL fill_corners: got %h %h %h want 00 80 ff",
                            dut.s_mem[0], dut.s_mem[128], dut.s_mem[255]);
        end
        scan_mem("fill");
    endtask

    task automatic test_done_hold();
        dut.s_mem[17]  = 8'hAA; ref_mem[17]  = 8'hAA;
        dut.s_mem[200] = 8'h55; ref_mem[200] = 8'h55;
        run_fill("done", 20);
        scan_mem("done");
        dut.s_mem[17]  = 8'd17;  ref_mem[17]  = 8'd17;
        dut.s_mem[200] = 8'd200; ref_mem[200] = 8'd200;
    endtask

    task automatic test_abort();
        KEY[3] = 1'b1;
        tick();
        total++;
        if (LEDR !== 10'd0) begin
            bad++; $display("FAIL done_reset_ledr: got %h want 0", LEDR);
        end
        preload_aa();
        tick();
        KEY[3] = 1'b0;
        run_fill("abort", 101);
        KEY[3] = 1'b1;
        tick();
        total++;
        if (LEDR !== 10'd0) begin
            bad++; $display("FAIL abort_ledr: got %h want 0", LEDR);
        end
        total++;
        if (dut.s_mem[200] !== 8'hAA || dut.s_mem[98] !== 8'd98) begin
            bad++; $display("FAIL abort_partial: got s[98]=%h s[200]=%h want 62 aa",
                            dut.s_mem[98], dut.s_mem[200]);
        end
        scan_mem("abort");
        tick();
        KEY[3] = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_fill("refill", 257);
        scan_mem("refill");
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a);
        scan_mem("refill_addr");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        KEY   = 4'b1000;
        test_reset();
        test_fill();
        test_done_hold();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
